// File: rtl/jstk2_pkg.sv
// Shared definitions for the Pmod JSTK2 SPI responder: packet geometry, FSM states,
// byte layout and command codes.
package jstk2_pkg;

  localparam int unsigned PKT_BYTES = 5;
  localparam int unsigned PKT_BITS  = PKT_BYTES * 8;

  // Position of each field in the packet, byte 0 is shifted out first
  localparam int unsigned BYTE_X_LO = 0;
  localparam int unsigned BYTE_X_HI = 1;
  localparam int unsigned BYTE_Y_LO = 2;
  localparam int unsigned BYTE_Y_HI = 3;
  localparam int unsigned BYTE_BTN  = 4;

  localparam logic [7:0] CMD_SET_LED = 8'h84;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  // Build the MSB-first shift image of one position/button packet
  function automatic logic [PKT_BITS-1:0] pack_packet(input logic [9:0] x,
                                                      input logic [9:0] y,
                                                      input logic [1:0] btn);
    logic [7:0]          pkt_bytes [PKT_BYTES];
    logic [PKT_BITS-1:0] pkt;
    pkt_bytes[BYTE_X_LO] = x[7:0];
    pkt_bytes[BYTE_X_HI] = {6'b0, x[9:8]};
    pkt_bytes[BYTE_Y_LO] = y[7:0];
    pkt_bytes[BYTE_Y_HI] = {6'b0, y[9:8]};
    pkt_bytes[BYTE_BTN]  = {6'b0, btn};
    pkt = '0;
    for (int i = 0; i < int'(PKT_BYTES); i++) begin
      pkt[PKT_BITS-1-8*i -: 8] = pkt_bytes[i];
    end
    return pkt;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for one asynchronous SPI input, with single-cycle
// rise/fall pulses derived from the synchronised copy.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw input through the chain; prev holds the last synchronised value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain resets low so a slave select held low across reset never looks like a new edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/jstk2_spi_responder.sv
// Pmod JSTK2 SPI slave emulator (mode 0, MSB first). Answers each frame with a
// snapshot of x_pos/y_pos/buttons packed into 5 bytes.
// Build option: define JSTK2_RX_CMD_EN to capture the first MOSI byte into rx_cmd.
module jstk2_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PKT_BYTES   = jstk2_pkg::PKT_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [1:0] buttons,
  output logic       miso,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] rx_cmd,
  output logic       cmd_valid
);

  import jstk2_pkg::*;

  // Bits beyond the 40-bit image read back as zero when PKT_BYTES is larger
  localparam logic [5:0] FRAME_BITS = 6'(PKT_BYTES * 8);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic unused_ss_lvl, unused_sclk_lvl;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ss),
    .q_o    (unused_ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk),
    .q_o    (unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

`ifdef JSTK2_RX_CMD_EN
  logic mosi_s;
  logic unused_mosi_rise, unused_mosi_fall;
  logic [7:0] cmd_sh_q, cmd_sh_d;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );
`else
  logic unused_mosi;
  assign unused_mosi = mosi;
`endif

  state_e              state_q, state_d;
  logic [PKT_BITS-1:0] sh_q, sh_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                miso_q, miso_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          rx_cmd_q, rx_cmd_d;
  logic                cmd_valid_q, cmd_valid_d;

  // Next-state logic: ss edges take priority over sclk edges in the same cycle
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    miso_d       = miso_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    rx_cmd_d     = rx_cmd_q;
    cmd_valid_d  = 1'b0;
`ifdef JSTK2_RX_CMD_EN
    cmd_sh_d     = cmd_sh_q;
`endif
    unique case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        sh_d      = pack_packet(x_pos, y_pos, buttons);
        miso_d    = sh_d[PKT_BITS-1];
        busy_d    = 1'b1;
        bit_cnt_d = '0;
        state_d   = SHIFT;
`ifdef JSTK2_RX_CMD_EN
        cmd_sh_d  = '0;
`endif
        if (ss_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          miso_d    = 1'b0;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
          if (bit_cnt_q >= FRAME_BITS) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
`ifdef JSTK2_RX_CMD_EN
            rx_cmd_d     = cmd_sh_q;
            cmd_valid_d  = 1'b1;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef JSTK2_RX_CMD_EN
          if (bit_cnt_q < 6'd8) cmd_sh_d = {cmd_sh_q[6:0], mosi_s};
`endif
        end else if (sclk_fall) begin
          sh_d   = sh_q << 1;
          miso_d = (bit_cnt_q >= FRAME_BITS) ? 1'b0 : sh_d[PKT_BITS-1];
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rx_cmd_q     <= '0;
      cmd_valid_q  <= 1'b0;
`ifdef JSTK2_RX_CMD_EN
      cmd_sh_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rx_cmd_q     <= rx_cmd_d;
      cmd_valid_q  <= cmd_valid_d;
`ifdef JSTK2_RX_CMD_EN
      cmd_sh_q     <= cmd_sh_d;
`endif
    end
  end

  assign miso       = miso_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign rx_cmd     = rx_cmd_q;
  assign cmd_valid  = cmd_valid_q;

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Self-checking bench for jstk2_spi_responder: bit-banged SPI master, packet model
// computed from the field layout, directed scenarios plus randomized frames.
`timescale 1ns/1ps
module tb_jstk2_spi_responder;

  localparam int HALF = 6;  // SCLK half-period in clk cycles
`ifdef JSTK2_RX_CMD_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi;
  logic [9:0] x_pos, y_pos;
  logic [1:0] buttons;
  logic       miso, busy, frame_done, cmd_valid;
  logic [7:0] rx_cmd;

  int         checks = 0;
  int         errors = 0;
  int         fd_count = 0;
  int         cv_count = 0;
  int         misaligned = 0;
  int         ss_hi_cnt = 0;
  logic [7:0] rx_exp = 8'h00;
  logic [47:0] got;

  always #5 clk = ~clk;

  jstk2_spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .sclk       (sclk),
    .mosi       (mosi),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .miso       (miso),
    .busy       (busy),
    .frame_done (frame_done),
    .rx_cmd     (rx_cmd),
    .cmd_valid  (cmd_valid)
  );

  // Expected packet straight from the field layout: X_lo, X_hi, Y_lo, Y_hi, BTN
  function automatic logic [39:0] model_pkt(input logic [9:0] x, input logic [9:0] y,
                                            input logic [1:0] b);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, b};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle checks: quiet line while deselected, pulse bookkeeping
  always @(negedge clk) begin
    if (rst) begin
      ss_hi_cnt = 0;
    end else begin
      if (ss) ss_hi_cnt++;
      else ss_hi_cnt = 0;
      if (ss_hi_cnt >= 6) begin
        chk("idle_miso", {47'b0, miso}, 48'd0);
        chk("idle_busy", {47'b0, busy}, 48'd0);
      end
      if (frame_done === 1'b1) fd_count++;
      if (cmd_valid === 1'b1) cv_count++;
      if (cmd_valid === 1'b1 && frame_done !== 1'b1) misaligned++;
    end
  end

  // One master transaction of nbits SCLK periods; x_pos may be changed before bit change_at
  task automatic spi_frame(input int nbits, input logic [7:0] cmd, input int change_at,
                           input logic [9:0] new_x, output logic [47:0] bits);
    logic [39:0] pkt;
    int          fd0, cv0;
    fd0  = fd_count;
    cv0  = cv_count;
    pkt  = model_pkt(x_pos, y_pos, buttons);
    bits = '0;
    @(negedge clk);
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == change_at) x_pos = new_x;
      mosi = (i < 8) ? cmd[7-i] : 1'($urandom_range(0, 1));
      bits[47-i] = miso;
      chk("miso_bit", {47'b0, miso}, {47'b0, (i < 40) ? pkt[39-i] : 1'b0});
      chk("busy_in_frame", {47'b0, busy}, 48'd1);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    ss = 1'b1;
    repeat (10) @(negedge clk);
    chk("frame_done_count", 48'(fd_count - fd0), (nbits >= 40) ? 48'd1 : 48'd0);
    chk("cmd_valid_count", 48'(cv_count - cv0), (nbits >= 40 && RX_EN) ? 48'd1 : 48'd0);
    chk("busy_after", {47'b0, busy}, 48'd0);
    if (nbits >= 40 && RX_EN) rx_exp = cmd;
    chk("rx_cmd", {40'b0, rx_cmd}, {40'b0, rx_exp});
  endtask

  initial begin
    int fd0;
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_pos = '0; y_pos = '0; buttons = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {47'b0, miso}, 48'd0);
    chk("rst_busy", {47'b0, busy}, 48'd0);
    chk("rst_frame_done", {47'b0, frame_done}, 48'd0);
    chk("rst_rx_cmd", {40'b0, rx_cmd}, 48'd0);
    chk("rst_cmd_valid", {47'b0, cmd_valid}, 48'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic read, command byte 84
    x_pos = 10'h3FF; y_pos = 10'h200; buttons = 2'b10;
    spi_frame(40, 8'h84, -1, 10'h0, got);
    chk("t1_byte0", {40'b0, got[47:40]}, 48'hFF);
    chk("t1_byte1", {40'b0, got[39:32]}, 48'h03);
    chk("t1_byte2", {40'b0, got[31:24]}, 48'h00);
    chk("t1_byte3", {40'b0, got[23:16]}, 48'h02);
    chk("t1_byte4", {40'b0, got[15:8]},  48'h02);
`ifdef JSTK2_RX_CMD_EN
    chk("t6_rx_cmd", {40'b0, rx_cmd}, 48'h84);
`else
    chk("t6_rx_cmd", {40'b0, rx_cmd}, 48'h00);
`endif

    // Snapshot holds while x_pos changes mid-frame
    x_pos = 10'h155;
    spi_frame(40, 8'h3C, 8, 10'h000, got);
    chk("t2_byte0", {40'b0, got[47:40]}, 48'h55);
    chk("t2_byte1", {40'b0, got[39:32]}, 48'h01);
    spi_frame(40, 8'h00, -1, 10'h0, got);
    chk("t2_next_byte0", {40'b0, got[47:40]}, 48'h00);
    chk("t2_next_byte1", {40'b0, got[39:32]}, 48'h00);

    // Over-long frame reads zeros past bit 39
    spi_frame(48, 8'hA5, -1, 10'h0, got);
    chk("t3_tail", {40'b0, got[7:0]}, 48'h00);

    // Aborted frame then a full one
    x_pos = 10'h2AB; y_pos = 10'h1CD; buttons = 2'b01;
    spi_frame(20, 8'h11, -1, 10'h0, got);
    spi_frame(40, 8'h22, -1, 10'h0, got);
    chk("t4_last_byte", {40'b0, got[15:8]}, 48'h01);

    // Reset during bit 15 with ss held low
    fd0 = fd_count;
    @(negedge clk);
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; repeat (HALF) @(negedge clk);
    end
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_exp = 8'h00;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("t5_miso", {47'b0, miso}, 48'd0);
    chk("t5_busy", {47'b0, busy}, 48'd0);
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      chk("t5_ignored_miso", {47'b0, miso}, 48'd0);
      chk("t5_ignored_busy", {47'b0, busy}, 48'd0);
      sclk = 1'b0; repeat (HALF) @(negedge clk);
    end
    ss = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_no_frame_done", 48'(fd_count - fd0), 48'd0);
    chk("t5_rx_cmd", {40'b0, rx_cmd}, 48'h00);
    spi_frame(40, 8'h84, -1, 10'h0, got);

    // Randomized frames: positions, length, commands and mid-frame changes
    for (int n = 0; n < 30; n++) begin
      int r, len, chg;
      x_pos   = 10'($urandom);
      y_pos   = 10'($urandom);
      buttons = 2'($urandom);
      r = $urandom_range(0, 9);
      if (r < 2) len = $urandom_range(1, 39);
      else if (r < 4) len = $urandom_range(41, 48);
      else len = 40;
      chg = $urandom_range(0, 39);
      spi_frame(len, 8'($urandom), chg, 10'($urandom), got);
    end

    chk("cmd_valid_without_frame_done", 48'(misaligned), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
